// File: rtl/reg_bus_writer.sv
// Byte-stream command decoder for a bank of 32-bit dual-clock-enable control registers.
// Decodes write (0x57) and read (0x52) frames and returns a byte-stream response.
module reg_bus_writer #(
    parameter int N_REGS  = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 cmd_data,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    output logic [7:0]                 rsp_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [N_REGS-1:0]          reg_sel,
    output logic                       wr_stb,
    output logic [31:0]                wr_data,
    input  logic [32*N_REGS-1:0]       rd_bus,
    output logic [7:0]                 err_cnt
);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'hA5;
    localparam logic [7:0] RSP_ERR  = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_WSTB,
        S_RD,
        S_RSP,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        is_write;
    logic [7:0]  addr;
    logic [2:0]  byte_cnt;
    logic [15:0] idle_cnt;
    logic        addr_ok;
    logic        idle_expired;
    logic [31:0] rd_word;

    assign addr_ok      = int'(cmd_data) < N_REGS;
    assign idle_expired = (int'(idle_cnt) + 1) >= TIMEOUT;

    // Addressed register word, selected by the stored address.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (int'(addr) == i) begin
                rd_word = rd_bus[32*i +: 32];
            end
        end
    end

    always_comb begin
        reg_sel = '0;
        for (int i = 0; i < N_REGS; i++) begin
            reg_sel[i] = (state == S_WSTB) && (int'(addr) == i);
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        wr_stb    = 1'b0;
        case (state)
            S_IDLE, S_ADDR, S_DATA: cmd_ready = 1'b1;
            S_WSTB:                 wr_stb    = 1'b1;
            S_RSP, S_ERR:           rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // cmd_ready is high in IDLE/ADDR/DATA, so cmd_valid alone marks an accepted byte there.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_next = (cmd_data == OP_WRITE || cmd_data == OP_READ) ? S_ADDR : S_ERR;
                end
            end
            S_ADDR: begin
                if (cmd_valid) begin
                    if (!addr_ok) begin
                        state_next = S_ERR;
                    end else begin
                        state_next = is_write ? S_DATA : S_RD;
                    end
                end else if (idle_expired) begin
                    state_next = S_ERR;
                end
            end
            S_DATA: begin
                if (cmd_valid) begin
                    if (byte_cnt == 3'd3) begin
                        state_next = S_WSTB;
                    end
                end else if (idle_expired) begin
                    state_next = S_ERR;
                end
            end
            S_WSTB: state_next = S_RSP;
            S_RD:   state_next = S_RSP;
            S_RSP: begin
                if (rsp_ready && byte_cnt == 3'd0) begin
                    state_next = S_IDLE;
                end
            end
            S_ERR: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_write <= 1'b0;
            addr     <= '0;
            byte_cnt <= '0;
            idle_cnt <= '0;
            wr_data  <= '0;
            rsp_data <= '0;
            err_cnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register here sees pre-edge values.
            idle_cnt <= '0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        is_write <= (cmd_data == OP_WRITE);
                    end
                end
                S_ADDR: begin
                    if (cmd_valid) begin
                        addr     <= cmd_data;
                        byte_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (cmd_valid) begin
                        wr_data  <= {wr_data[23:0], cmd_data};
                        byte_cnt <= byte_cnt + 3'd1;
                    end else begin
                        idle_cnt <= idle_cnt + 16'd1;
                    end
                end
                S_WSTB: begin
                    rsp_data <= RSP_OK;
                    byte_cnt <= 3'd0;
                end
                S_RD: begin
                    // The snapshot reuses wr_data as the response shift register.
                    wr_data  <= rd_word;
                    rsp_data <= RSP_OK;
                    byte_cnt <= 3'd4;
                end
                S_RSP: begin
                    if (rsp_ready && byte_cnt != 3'd0) begin
                        rsp_data <= wr_data[31:24];
                        wr_data  <= {wr_data[23:0], 8'h00};
                        byte_cnt <= byte_cnt - 3'd1;
                    end
                end
                default: ;
            endcase

            if (state != S_ERR && state_next == S_ERR) begin
                rsp_data <= RSP_ERR;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_bus_writer.sv
// Scoreboard bench for reg_bus_writer: a frame-level reference model queues expected
// responses and strobes; monitors compare whatever the DUT presents.
module tb_reg_bus_writer;

    localparam int N_REGS  = 16;
    localparam int TIMEOUT = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [7:0]             cmd_data;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [7:0]             rsp_data;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [N_REGS-1:0]      reg_sel;
    logic                   wr_stb;
    logic [31:0]            wr_data;
    logic [32*N_REGS-1:0]   rd_bus;
    logic [7:0]             err_cnt;

    reg_bus_writer #(.N_REGS(N_REGS), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .rsp_data  (rsp_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .reg_sel   (reg_sel),
        .wr_stb    (wr_stb),
        .wr_data   (wr_data),
        .rd_bus    (rd_bus),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    // Register bank the block drives: a register loads when both clock enables are high.
    logic [31:0] bank [N_REGS];
    logic        preload_en = 1'b0;
    int          preload_idx = 0;
    logic [31:0] preload_val = '0;

    always @(posedge clk) begin
        if (preload_en) begin
            bank[preload_idx] <= preload_val;
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                if (reg_sel[i] && wr_stb) bank[i] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_bus = '0;
        for (int i = 0; i < N_REGS; i++) rd_bus[32*i +: 32] = bank[i];
    end

    // Reference model and scoreboard queues.
    typedef struct {
        logic [7:0] data;
        bit         chk_err;
        logic [7:0] err;
    } rsp_exp_t;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } stb_exp_t;

    rsp_exp_t    rsp_q[$];
    stb_exp_t    stb_q[$];
    logic [31:0] model_mem [N_REGS];
    int          model_err = 0;
    int          rsp_mode = 0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_rsp(input logic [7:0] d, input bit chk, input logic [7:0] e);
        rsp_exp_t x;
        x.data = d;
        x.chk_err = chk;
        x.err = e;
        rsp_q.push_back(x);
    endtask

    task automatic model_write(input int a, input logic [31:0] d);
        stb_exp_t s;
        s.addr = a;
        s.data = d;
        stb_q.push_back(s);
        model_mem[a] = d;
        push_rsp(8'hA5, 1'b0, 8'h00);
    endtask

    task automatic model_read(input int a);
        logic [31:0] v;
        v = model_mem[a];
        push_rsp(8'hA5, 1'b0, 8'h00);
        for (int k = 3; k >= 0; k--) push_rsp(v[8*k +: 8], 1'b0, 8'h00);
    endtask

    task automatic model_error();
        if (model_err < 255) model_err++;
        push_rsp(8'hEE, 1'b1, 8'(model_err));
    endtask

    // Response monitor: every accepted byte is popped and compared; held bytes must stay put.
    bit         prev_pend = 1'b0;
    logic [7:0] prev_data = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (prev_pend) begin
                check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
                check("rsp_hold_data", 32'(rsp_data), 32'(prev_data));
            end
            prev_pend = rsp_valid && !rsp_ready && !reset;
            prev_data = rsp_data;
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_data), 32'hFFFF_FFFF);
                end else begin
                    rsp_exp_t e;
                    e = rsp_q.pop_front();
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                    if (e.chk_err) check("err_cnt", 32'(err_cnt), 32'(e.err));
                end
            end
            if (wr_stb) begin
                if (stb_q.size() == 0) begin
                    check("unexpected_stb", 32'(reg_sel), 32'hFFFF_FFFF);
                end else begin
                    stb_exp_t s;
                    s = stb_q.pop_front();
                    check("stb_reg_sel", 32'(reg_sel), 32'(1) << s.addr);
                    check("stb_wr_data", wr_data, s.data);
                end
            end else if (reg_sel != '0) begin
                check("reg_sel_idle", 32'(reg_sel), 32'd0);
            end
        end
    end

    // Downstream ready: always, alternating, or random.
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rsp_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = !rsp_ready;
                default: rsp_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        cmd_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        cmd_data  = b;
        cmd_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 3000 && !acc; n++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        check("cmd_accept", 32'(acc), 32'd1);
    endtask

    function automatic int rgap();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return TIMEOUT - 1;
        if (r < 5) return 0;
        return $urandom_range(1, 3);
    endfunction

    task automatic write_frame(input logic [7:0] a, input logic [31:0] d, input bit zero_gap);
        if (int'(a) < N_REGS) model_write(int'(a), d);
        else model_error();
        send_byte(8'h57, zero_gap ? 0 : rgap());
        send_byte(a, zero_gap ? 0 : rgap());
        if (int'(a) < N_REGS) begin
            for (int k = 3; k >= 0; k--) send_byte(d[8*k +: 8], zero_gap ? 0 : rgap());
        end
    endtask

    task automatic read_frame(input logic [7:0] a, input bit zero_gap);
        if (int'(a) < N_REGS) model_read(int'(a));
        else model_error();
        send_byte(8'h52, zero_gap ? 0 : rgap());
        send_byte(a, zero_gap ? 0 : rgap());
    endtask

    task automatic bad_op_frame(input logic [7:0] op);
        model_error();
        send_byte(op, 0);
    endtask

    // Frame stops after `sent` bytes past the opcode, then the link idles past the limit.
    task automatic timeout_frame(input bit wr, input int sent, input int extra);
        model_error();
        send_byte(wr ? 8'h57 : 8'h52, rgap());
        if (wr) begin
            for (int k = 0; k < sent; k++) begin
                send_byte(k == 0 ? 8'($urandom_range(0, N_REGS - 1)) : 8'($urandom), rgap());
            end
        end
        repeat (TIMEOUT + extra) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 6000 && (rsp_q.size() != 0 || stb_q.size() != 0); n++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        check("stb_q_drained", 32'(stb_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_reg_sel", 32'(reg_sel), 32'd0);
        check("rst_wr_stb", 32'(wr_stb), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        repeat (2) @(posedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < N_REGS; i++) begin
            preload_en  = 1'b1;
            preload_idx = i;
            preload_val = (i == 5) ? 32'h1234_5678 : $urandom;
            model_mem[i] = preload_val;
            @(posedge clk);
            #1;
        end
        preload_en = 1'b0;

        // Back-to-back write, then read it back.
        rsp_mode = 0;
        write_frame(8'h03, 32'hDEAD_BEEF, 1'b1);
        read_frame(8'h03, 1'b1);
        drain();

        // Read with a stalling downstream.
        rsp_mode = 1;
        read_frame(8'h05, 1'b1);
        drain();

        // Bad opcode, out-of-range write, then a good read.
        rsp_mode = 0;
        bad_op_frame(8'h41);
        write_frame(8'h10, 32'h0, 1'b1);
        read_frame(8'h07, 1'b1);
        drain();
        check("err_cnt_after_errors", 32'(err_cnt), 32'd2);

        // Idle exactly the limit inside a write, then a normal write to the same register.
        model_error();
        send_byte(8'h57, 0);
        send_byte(8'h02, 0);
        send_byte(8'hAA, 0);
        repeat (TIMEOUT) begin
            @(posedge clk);
            #1;
        end
        write_frame(8'h02, 32'hCAFE_F00D, 1'b0);
        read_frame(8'h02, 1'b0);
        drain();

        // Reset mid-frame: nothing comes out and register 1 keeps its value.
        send_byte(8'h57, 0);
        send_byte(8'h01, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        reset = 1'b1;
        model_err = 0;
        check_reset_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        read_frame(8'h01, 1'b1);
        drain();

        // Saturating error counter.
        for (int i = 0; i < 260; i++) bad_op_frame(8'h00);
        drain();
        check("err_cnt_saturated", 32'(err_cnt), 32'd255);

        // Randomized traffic.
        rsp_mode = 2;
        for (int f = 0; f < 200; f++) begin
            int kind;
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1, 2, 3: write_frame(8'($urandom_range(0, N_REGS - 1)), $urandom, 1'b0);
                4, 5, 6:    read_frame(8'($urandom_range(0, N_REGS - 1)), 1'b0);
                7: begin
                    logic [7:0] op;
                    op = 8'($urandom);
                    if (op == 8'h57 || op == 8'h52) op = 8'hFF;
                    bad_op_frame(op);
                end
                8: begin
                    if ($urandom_range(0, 1) == 1) write_frame(8'($urandom_range(N_REGS, 255)), $urandom, 1'b0);
                    else read_frame(8'($urandom_range(N_REGS, 255)), 1'b0);
                end
                default: begin
                    if ($urandom_range(0, 1) == 1) timeout_frame(1'b1, $urandom_range(0, 4), $urandom_range(0, 3));
                    else timeout_frame(1'b0, 0, $urandom_range(0, 3));
                end
            endcase
        end
        drain();
        check("err_cnt_final", 32'(err_cnt), 32'(model_err));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_bus_writer.md
Name: reg_bus_writer

Overview:
- Byte-stream command decoder that drives a bank of 32-bit control registers built as dual-clock-enable, async-reset registers.
- Per register it drives clk_en1 = reg_sel[i] and clk_en2 = wr_stb; the shared in bus is wr_data.
- It also returns register contents from the registers' out buses (rd_bus) as a byte-stream response.
- Sits between the serial/IPbus byte link and the control register bank.

Parameters:
- N_REGS, 16, number of registers addressed (1..256); valid addresses 0..N_REGS-1.
- TIMEOUT, 1023, max idle cycles allowed between bytes inside a frame (1..65535).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_data  in  8  command byte
- cmd_valid  in  1  cmd_data valid
- cmd_ready  out  1  block accepts cmd_data this cycle
- rsp_data  out  8  response byte
- rsp_valid  out  1  rsp_data valid
- rsp_ready  in  1  downstream accepts rsp_data
- reg_sel  out  N_REGS  one-hot register select (clk_en1 per register)
- wr_stb  out  1  write strobe (clk_en2, common to all registers)
- wr_data  out  32  write data (register in bus)
- rd_bus  in  32*N_REGS  register outputs; register i at bits [32i+31:32i]
- err_cnt  out  8  saturating protocol-error counter

Behaviour:
- Reset is asynchronous and active-high; clock is clk. Reset values: state IDLE, cmd_ready 1, rsp_valid 0, rsp_data 0x00, reg_sel 0, wr_stb 0, wr_data 0, err_cnt 0, timeout counter 0.
- Reset asserted mid-frame aborts the frame immediately. No strobe is issued and no response byte is emitted.
- A byte is transferred when cmd_valid and cmd_ready are both high on a rising edge. A response byte is transferred when rsp_valid and rsp_ready are both high.
- While rsp_valid is high, rsp_data is stable. rsp_valid is held until accepted.
- Frame formats:
  - Write: opcode 0x57, addr, D3, D2, D1, D0 (MSB first).
  - Read: opcode 0x52, addr.
- Responses:
  - Good write: 0xA5.
  - Good read: 0xA5 then 4 data bytes, MSB first.
  - Any error: a single 0xEE.
- States:
  - IDLE: cmd_ready 1. Opcode 0x57 or 0x52 -> ADDR, with the opcode stored. Any other byte -> ERR.
  - ADDR: cmd_ready 1. Address byte stored. addr >= N_REGS -> ERR (for a write, the 4 data bytes are not consumed). Valid write -> DATA with byte count 0. Valid read -> RD.
  - DATA: cmd_ready 1. Each byte is shifted into wr_data from the LSB end (wr_data <= {wr_data[23:0], byte}). After the 4th byte -> WSTB.
  - WSTB: one cycle; cmd_ready 0. wr_stb = 1 and reg_sel = one-hot(addr) on this cycle only. wr_data is unchanged since the previous cycle, so the register captures on the edge ending WSTB. Next state RSP with header 0xA5, byte count 0.
  - RD: one cycle; cmd_ready 0. The addressed 32-bit word of rd_bus is snapshotted into the shift register. Next state RSP with header 0xA5, byte count 4.
  - RSP: cmd_ready 0. Emits the header, then the remaining bytes MSB first. After the last accepted byte -> IDLE.
  - ERR: cmd_ready 0. err_cnt increments, saturating at 255. Emits a single 0xEE, then -> IDLE.
- Outside WSTB, reg_sel = 0 and wr_stb = 0. Exactly one strobe is issued per good write frame.
- wr_data is overwritten by a read snapshot. This is harmless because wr_stb is 0 outside WSTB.
- Timeout:
  - In ADDR and DATA, a counter increments on each cycle with no accepted byte and clears on each accepted byte.
  - Reaching TIMEOUT -> ERR. That frame emits 0xEE and issues no strobe.
  - The counter does not run in IDLE, RSP or ERR.
- A read value reflects rd_bus in the RD cycle. A write to the same register followed by a read returns the new value.
- A stalled rsp_ready holds the block indefinitely. No command bytes are accepted until the response completes.

Test Plan:
- Write, N_REGS=16: bytes 57 03 DE AD BE EF, all valid every cycle -> exactly one cycle with wr_stb=1, reg_sel=0x0008, wr_data=0xDEADBEEF; then response A5; register 3 reads 0xDEADBEEF.
- Read: register 5 rd_bus=0x12345678; send 52 05 with rsp_ready toggling 1/0 -> response A5 12 34 56 78, each byte held stable while stalled; no wr_stb.
- Errors, starting from err_cnt 0: opcode 0x41 -> response EE, err_cnt=1; then write to addr 0x10 -> response EE, err_cnt=2, no strobe; then a valid read -> A5 plus 4 bytes.
- Timeout with TIMEOUT=8: send 57 02 AA, then idle 8 cycles -> response EE, err_cnt increments, no wr_stb; a following write to reg 2 succeeds normally.
- Reset after 57 01 11 22: assert reset 2 cycles -> all outputs at reset values, no strobe, no response; then 52 01 returns register 1 contents unchanged.
- err_cnt saturation: 260 bad opcodes -> err_cnt=255 and 260 EE responses.
